// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package if_id_queue_pkg;

  localparam int          IFQ_DEPTH_DEFAULT = 2;
  localparam logic [31:0] IFQ_PC_STEP       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch->decode FIFO; a push is visible at the head one cycle later, with no combinational in->out path.
// in_ready comes from the registered count only, so a full queue refuses a push even while popping. IFQ_STAT_EN adds stall/flush counters.
`ifndef IFQ_NOP
`define IFQ_NOP 32'h0
`endif

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  output logic [31:0]      out_inst,
  output logic [PTR_W:0]   count
`ifdef IFQ_STAT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_drops
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  ifq_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count_q;
  logic                 push;
  logic                 pop;
  ifq_entry_t           head;

  assign count     = count_q;
  assign in_ready  = (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head is forced to a NOP at pc 0 while empty so stale entries never leak out.
  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head.pc   : 32'h0;
  assign out_inst = out_valid ? head.inst : `IFQ_NOP;
  assign out_pc4  = out_pc + IFQ_PC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

`ifdef IFQ_STAT_EN
  logic [32:0] drops_sum;

  assign drops_sum = {1'b0, flush_drops} + 33'(count_q);

  // Counters survive flush; only reset clears them. Both saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush) begin
        flush_drops <= drops_sum[32] ? '1 : drops_sum[31:0];
      end
    end
  end
`endif

endmodule
